// File: rtl/universal_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_pkg
//   Shared definitions for the universal shift register and the blocks that
//   drive it: the MODE operation encodings and a helper that classifies a
//   mode as a shift event (the events the frame counter tracks).
// -----------------------------------------------------------------------------
package universal_shift_reg_pkg;

  // Operation select carried on the 3-bit MODE port. All eight codes are
  // defined, so no MODE value can produce X on the register.
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ASR   = 3'b101,
    MODE_LOAD  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  // True for the five modes that move bits and therefore advance the frame
  // counter, whatever their direction.
  function automatic logic is_shift(mode_e mode);
    return (mode inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});
  endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// -----------------------------------------------------------------------------
// shift_frame_counter
//   Counts shift events within a WIDTH-shift frame and raises a one-cycle
//   registered pulse after the WIDTH-th shift of each frame.
//
// Ports
//   Clk        in   rising-edge clock
//   RST        in   synchronous active-high reset
//   EN         in   0 = hold the count and drop any pulse
//   step       in   a shift happens this cycle
//   clr        in   abort the current frame (LOAD/CLEAR); wins over step
//   CNT        out  shifts completed in the current frame, 0..WIDTH-1
//   FRAME_DONE out  1-cycle pulse in the cycle after the frame's last shift
// -----------------------------------------------------------------------------
module shift_frame_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             step,
  input  logic             clr,
  output logic [CNT_W-1:0] CNT,
  output logic             FRAME_DONE
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (EN) begin
      if (clr) begin
        // Aborting on the wrap cycle also swallows that frame's pulse.
        cnt_d = '0;
      end else if (step) begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (RST) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign CNT        = cnt_q;
  assign FRAME_DONE = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   Parametrised universal shift register: hold, logical/arithmetic/rotate
//   shifts in both directions, parallel load and clear, serial in/out at both
//   ends, plus a frame counter that flags every completed WIDTH-shift frame.
//
// Ports
//   Clk        in   rising-edge clock
//   RST        in   synchronous active-high reset (overrides EN/MODE)
//   EN         in   operation enable; 0 = hold everything
//   MODE       in   operation select (universal_shift_reg_pkg::mode_e)
//   SER_R      in   serial bit entering the LSB on SHL
//   SER_L      in   serial bit entering the MSB on SHR
//   D          in   parallel load data
//   Q          out  register contents
//   SO_MSB     out  Q[WIDTH-1], serial out for left shifts
//   SO_LSB     out  Q[0], serial out for right shifts
//   CNT        out  shifts completed in the current frame
//   FRAME_DONE out  1-cycle pulse after the WIDTH-th shift of a frame
// -----------------------------------------------------------------------------
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CNT_W     = (WIDTH <= 2) ? 1 : $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic             SER_R,
  input  logic             SER_L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO_MSB,
  output logic             SO_LSB,
  output logic [CNT_W-1:0] CNT,
  output logic             FRAME_DONE
);

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             step;
  logic             clr;

  assign mode = mode_e'(MODE);

  // Data path mode mux. step/clr are only raised while enabled, so the
  // counter sees exactly the shift and abort events the register performs.
  always_comb begin
    q_d  = q_q;
    step = 1'b0;
    clr  = 1'b0;
    if (EN) begin
      step = is_shift(mode);
      unique case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], SER_R};
        MODE_SHR:   q_d = {SER_L, q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        MODE_LOAD: begin
          q_d = D;
          clr = 1'b1;
        end
        MODE_CLEAR: begin
          q_d = '0;
          clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (RST) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  shift_frame_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_frame_counter (
    .Clk        (Clk),
    .RST        (RST),
    .EN         (EN),
    .step       (step),
    .clr        (clr),
    .CNT        (CNT),
    .FRAME_DONE (FRAME_DONE)
  );

  assign Q      = q_q;
  assign SO_MSB = q_q[WIDTH-1];
  assign SO_LSB = q_q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//   Self-checking bench for universal_shift_reg (WIDTH=8). A table of directed
//   vectors with hand-derived expectations, hand-written multi-cycle sequences
//   and a randomized run, all compared against an arithmetic reference model.
//   A second instance built with RESET_VAL=8'h3C checks the reset value.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;
  import universal_shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, ser_r, ser_l;
  logic [2:0] mode_s;
  logic [7:0] d;
  logic [7:0] q, q2;
  logic       so_msb, so_lsb, so_msb2, so_lsb2;
  logic [2:0] cnt, cnt2;
  logic       fd, fd2;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .Clk(clk), .RST(rst), .EN(en), .MODE(mode_s), .SER_R(ser_r), .SER_L(ser_l),
    .D(d), .Q(q), .SO_MSB(so_msb), .SO_LSB(so_lsb), .CNT(cnt), .FRAME_DONE(fd)
  );

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut_rv (
    .Clk(clk), .RST(rst), .EN(en), .MODE(mode_s), .SER_R(ser_r), .SER_L(ser_l),
    .D(d), .Q(q2), .SO_MSB(so_msb2), .SO_LSB(so_lsb2), .CNT(cnt2), .FRAME_DONE(fd2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec rules, plain arithmetic) ----------
  int   m_q      = 0;   // register value as an integer 0..255
  int   m_shifts = 0;   // shift events seen in the current frame
  logic m_fd     = 1'b0;

  task automatic model_step(input logic r, input logic e, input mode_e m,
                            input logic sr, input logic sl, input logic [7:0] dd);
    int qi;
    qi = m_q;
    m_fd = 1'b0;
    if (r) begin
      qi = 0;
      m_shifts = 0;
    end else if (e) begin
      case (m)
        MODE_SHL:   qi = (qi * 2) % 256 + int'(sr);
        MODE_SHR:   qi = qi / 2 + int'(sl) * 128;
        MODE_ROL:   qi = (qi * 2) % 256 + qi / 128;
        MODE_ROR:   qi = qi / 2 + (qi % 2) * 128;
        MODE_ASR:   qi = qi / 2 + (qi / 128) * 128;
        MODE_LOAD:  qi = int'(dd);
        MODE_CLEAR: qi = 0;
        default:    qi = m_q;
      endcase
      if (m == MODE_LOAD || m == MODE_CLEAR) m_shifts = 0;
      else if (m != MODE_HOLD) begin
        m_shifts++;
        if (m_shifts == 8) begin
          m_shifts = 0;
          m_fd = 1'b1;
        end
      end
    end
    m_q = qi;
  endtask

  // Drive one cycle, advance the model, then sample 1 time unit after the edge.
  task automatic drive(input logic r, input logic e, input mode_e m,
                       input logic sr, input logic sl, input logic [7:0] dd);
    rst = r; en = e; mode_s = m; ser_r = sr; ser_l = sl; d = dd;
    @(posedge clk);
    model_step(r, e, m, sr, sl, dd);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] mq;
    mq = 8'(m_q);
    check({tag, ".q"},      32'(q),      32'(mq));
    check({tag, ".cnt"},    32'(cnt),    32'(m_shifts));
    check({tag, ".fd"},     32'(fd),     32'(m_fd));
    check({tag, ".so_msb"}, 32'(so_msb), 32'(mq[7]));
    check({tag, ".so_lsb"}, 32'(so_lsb), 32'(mq[0]));
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct {
    logic       rst;
    logic       en;
    mode_e      mode;
    logic       ser_r;
    logic       ser_l;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic [2:0] exp_cnt;
    logic       exp_fd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic e, mode_e m, logic sr, logic sl,
                             logic [7:0] dd, logic [7:0] eq, logic [2:0] ec, logic ef);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.ser_r = sr; t.ser_l = sl; t.d = dd;
    t.exp_q = eq; t.exp_cnt = ec; t.exp_fd = ef;
    return t;
  endfunction

  int pulses[$];

  initial begin
    rst = 1'b1; en = 1'b0; mode_s = MODE_HOLD; ser_r = 1'b0; ser_l = 1'b0; d = 8'h00;

    // reset, load A5, reset again
    vecs.push_back(v(1, 0, MODE_HOLD,  0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(v(0, 1, MODE_LOAD,  0, 0, 8'hA5, 8'hA5, 0, 0));
    vecs.push_back(v(1, 1, MODE_SHL,   1, 1, 8'h00, 8'h00, 0, 0));
    // CLEAR then 8 SHLs with SER_R = 1,0,1,1,0,0,1,0
    vecs.push_back(v(0, 1, MODE_CLEAR, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   1, 0, 8'h00, 8'h01, 1, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   0, 0, 8'h00, 8'h02, 2, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   1, 0, 8'h00, 8'h05, 3, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   1, 0, 8'h00, 8'h0B, 4, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   0, 0, 8'h00, 8'h16, 5, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   0, 0, 8'h00, 8'h2C, 6, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   1, 0, 8'h00, 8'h59, 7, 0));
    vecs.push_back(v(0, 1, MODE_SHL,   0, 0, 8'h00, 8'hB2, 0, 1));
    vecs.push_back(v(0, 1, MODE_HOLD,  0, 0, 8'h00, 8'hB2, 0, 0));
    // LOAD 81 then rotate/arith/logical shifts
    vecs.push_back(v(0, 1, MODE_LOAD,  0, 0, 8'h81, 8'h81, 0, 0));
    vecs.push_back(v(0, 1, MODE_ROL,   0, 0, 8'h00, 8'h03, 1, 0));
    vecs.push_back(v(0, 1, MODE_ROR,   0, 0, 8'h00, 8'h81, 2, 0));
    vecs.push_back(v(0, 1, MODE_ROR,   0, 0, 8'h00, 8'hC0, 3, 0));
    vecs.push_back(v(0, 1, MODE_ASR,   0, 0, 8'h00, 8'hE0, 4, 0));
    vecs.push_back(v(0, 1, MODE_SHR,   0, 0, 8'h00, 8'h70, 5, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].ser_r, vecs[i].ser_l, vecs[i].d);
      check($sformatf("vec%0d.q", i),      32'(q),      32'(vecs[i].exp_q));
      check($sformatf("vec%0d.cnt", i),    32'(cnt),    32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d.fd", i),     32'(fd),     32'(vecs[i].exp_fd));
      check($sformatf("vec%0d.so_msb", i), 32'(so_msb), 32'(vecs[i].exp_q[7]));
      check($sformatf("vec%0d.so_lsb", i), 32'(so_lsb), 32'(vecs[i].exp_q[0]));
      if (vecs[i].rst) check($sformatf("vec%0d.rv_q", i), 32'(q2), 32'h3C);
    end

    // Suspension: 3 SHL, EN=0 x4, HOLD x2, 5 SHL; pulse only after the 8th shift.
    drive(0, 1, MODE_CLEAR, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) drive(0, 1, MODE_SHL, 1, 0, 8'h00);
    check("susp.cnt3", 32'(cnt), 32'd3);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, MODE_SHL, 1, 0, 8'h00);
      check_model("susp.en0");
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, MODE_HOLD, 0, 0, 8'h00);
      check_model("susp.hold");
    end
    check("susp.cnt_held", 32'(cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, MODE_SHL, 0, 0, 8'h00);
      check_model("susp.shl");
    end
    check("susp.fd_after8", 32'(fd), 32'd1);

    // LOAD on the wrap cycle: load wins, no pulse.
    drive(0, 1, MODE_CLEAR, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) drive(0, 1, MODE_ROL, 0, 0, 8'h00);
    drive(0, 1, MODE_LOAD, 0, 0, 8'h5A);
    check("wrapload.q",   32'(q),   32'h5A);
    check("wrapload.cnt", 32'(cnt), 32'd0);
    check("wrapload.fd",  32'(fd),  32'd0);
    drive(0, 1, MODE_HOLD, 0, 0, 8'h00);
    check("wrapload.fd_next", 32'(fd), 32'd0);

    // Reset on the wrap cycle: everything back to reset values, no pulse.
    for (int i = 0; i < 7; i++) drive(0, 1, MODE_SHR, 0, 1, 8'h00);
    check_model("wraprst.pre");
    drive(1, 1, MODE_SHR, 0, 1, 8'h00);
    check("wraprst.q",    32'(q),   32'h00);
    check("wraprst.cnt",  32'(cnt), 32'd0);
    check("wraprst.fd",   32'(fd),  32'd0);
    check("wraprst.rv_q", 32'(q2),  32'h3C);
    drive(0, 1, MODE_HOLD, 0, 0, 8'h00);
    check("wraprst.fd_next", 32'(fd), 32'd0);

    // 16 back-to-back SHR with SER_L=1: two pulses, 8 cycles apart.
    drive(0, 1, MODE_CLEAR, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, MODE_SHR, 0, 1, 8'h00);
      check_model("b2b");
      if (fd) pulses.push_back(i);
    end
    drive(0, 1, MODE_HOLD, 0, 0, 8'h00);
    check("b2b.q", 32'(q), 32'hFF);
    check("b2b.npulses", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) check("b2b.spacing", 32'(pulses[1] - pulses[0]), 32'd8);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, e;
      r = ($urandom_range(0, 99) < 3);
      e = ($urandom_range(0, 99) < 85);
      drive(r, e, mode_e'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 8'($urandom));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
